fx_mode_sync: RTL and testbench

//  Upstream control stage for the RGB channel-swap effect. Registers the 24-bit pixel

---
 rtl/fx_mode_sync.sv | 128 ++++++++++++
 tb/tb_fx_mode_sync.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_mode_sync.sv
// rtl/fx_mode_sync.sv - RGB swap fx mode control with frame-aligned mode changes (optional RGB_SWAP_AUTO_CYCLE_EN)
module fx_mode_sync #(
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter bit          VSYNC_POL       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] vid_pData_in,
    input  logic        vid_pVDE_in,
    input  logic        vid_pHSync_in,
    input  logic        vid_pVSync_in,
    input  logic [1:0]  mode_req,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        auto_en,
    output logic [23:0] vid_pData_out,
    output logic        vid_pVDE_out,
    output logic        vid_pHSync_out,
    output logic        vid_pVSync_out,
    output logic [1:0]  mode_out,
    output logic        mode_changed
);

    logic [23:0] data_q;
    logic        vde_q;
    logic        hs_q;
    logic        vs_q;
    logic        vs_prev_act_q;
    logic        pending_q, pending_d;
    logic [1:0]  stored_q, stored_d;
    logic [1:0]  mode_q, mode_d;
    logic        changed_q, changed_d;
    logic        vs_act;
    logic        fb;
    logic        accept;

`ifdef RGB_SWAP_AUTO_CYCLE_EN
    localparam logic [15:0] LAST_COUNT = 16'(FRAMES_PER_STEP - 1);
    logic [15:0] cnt_q, cnt_d;
`else
    logic        unused_auto_en;
    assign unused_auto_en = auto_en;
`endif

    // Frame boundary is the first cycle vsync is seen at its active level.
    assign vs_act    = (vid_pVSync_in == VSYNC_POL);
    assign fb        = vs_act && !vs_prev_act_q;
    assign req_ready = !pending_q && !rst;
    assign accept    = req_valid && req_ready;

    // Next-state for the request slot, mode and optional auto-cycle counter.
    always_comb begin
        pending_d = pending_q;
        stored_d  = stored_q;
        mode_d    = mode_q;
        changed_d = 1'b0;
`ifdef RGB_SWAP_AUTO_CYCLE_EN
        cnt_d     = cnt_q;
`endif
        if (fb && pending_q) begin
            // A manual request already waiting wins at the boundary.
            mode_d    = stored_q;
            changed_d = (stored_q != mode_q);
            pending_d = 1'b0;
`ifdef RGB_SWAP_AUTO_CYCLE_EN
            cnt_d     = 16'd0;
`endif
        end else begin
            // A request accepted in the boundary cycle itself waits for the next one.
            if (accept) begin
                pending_d = 1'b1;
                stored_d  = mode_req;
            end
`ifdef RGB_SWAP_AUTO_CYCLE_EN
            if (!auto_en) begin
                cnt_d = 16'd0;
            end else if (fb) begin
                if (cnt_q == LAST_COUNT) begin
                    mode_d    = mode_q + 2'd1;
                    changed_d = 1'b1;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
        end
    end

    // Video pipeline stage plus all control state; mode updates land with the delayed vsync.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q        <= 24'd0;
            vde_q         <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            vs_prev_act_q <= 1'b1;
            pending_q     <= 1'b0;
            stored_q      <= 2'b00;
            mode_q        <= 2'b00;
            changed_q     <= 1'b0;
`ifdef RGB_SWAP_AUTO_CYCLE_EN
            cnt_q         <= 16'd0;
`endif
        end else begin
            data_q        <= vid_pData_in;
            vde_q         <= vid_pVDE_in;
            hs_q          <= vid_pHSync_in;
            vs_q          <= vid_pVSync_in;
            vs_prev_act_q <= vs_act;
            pending_q     <= pending_d;
            stored_q      <= stored_d;
            mode_q        <= mode_d;
            changed_q     <= changed_d;
`ifdef RGB_SWAP_AUTO_CYCLE_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign vid_pData_out  = data_q;
    assign vid_pVDE_out   = vde_q;
    assign vid_pHSync_out = hs_q;
    assign vid_pVSync_out = vs_q;
    assign mode_out       = mode_q;
    assign mode_changed   = changed_q;

endmodule

// File: tb/tb_fx_mode_sync.sv
// tb/tb_fx_mode_sync.sv - self-checking bench for fx_mode_sync
module tb_fx_mode_sync;

    localparam int FPS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_i;
    logic        vde_i, hs_i, vs_i;
    logic [1:0]  mode_req;
    logic        req_valid;
    logic        req_ready;
    logic        auto_en;
    logic [23:0] data_o;
    logic        vde_o, hs_o, vs_o;
    logic [1:0]  mode_o;
    logic        changed_o;

    int vectors = 0;
    int miscompares = 0;

    fx_mode_sync #(.FRAMES_PER_STEP(FPS), .VSYNC_POL(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .vid_pData_in   (data_i),
        .vid_pVDE_in    (vde_i),
        .vid_pHSync_in  (hs_i),
        .vid_pVSync_in  (vs_i),
        .mode_req       (mode_req),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .auto_en        (auto_en),
        .vid_pData_out  (data_o),
        .vid_pVDE_out   (vde_o),
        .vid_pHSync_out (hs_o),
        .vid_pVSync_out (vs_o),
        .mode_out       (mode_o),
        .mode_changed   (changed_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [23:0] e_data = 0;
    logic        e_vde = 0, e_hs = 0, e_vs = 0;
    bit          m_prev_act = 1;
    bit          m_pending = 0;
    int          m_stored = 0;
    int          m_mode = 0;
    bit          m_changed = 0;
    int          m_frames = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_update();
        bit act, fb, ready, pend_before;
        act         = (vs_i == 1'b1);
        fb          = act && !m_prev_act;
        ready       = !m_pending && !rst;
        pend_before = m_pending;
        if (rst) begin
            e_data = 0; e_vde = 0; e_hs = 0; e_vs = 0;
            m_prev_act = 1; m_pending = 0; m_stored = 0;
            m_mode = 0; m_changed = 0; m_frames = 0;
        end else begin
            e_data = data_i; e_vde = vde_i; e_hs = hs_i; e_vs = vs_i;
            m_prev_act = act;
            m_changed = 0;
            if (fb && pend_before) begin
                m_changed = (m_stored != m_mode);
                m_mode = m_stored;
                m_pending = 0;
                m_frames = 0;
            end else begin
                if (req_valid && ready) begin
                    m_pending = 1;
                    m_stored = int'(mode_req);
                end
`ifdef RGB_SWAP_AUTO_CYCLE_EN
                if (!auto_en) m_frames = 0;
                else if (fb) begin
                    m_frames++;
                    if (m_frames == FPS) begin
                        m_mode = (m_mode + 1) % 4;
                        m_changed = 1;
                        m_frames = 0;
                    end
                end
`endif
            end
        end
    endfunction

    task automatic check_all();
        chk("data", 32'(data_o), 32'(e_data));
        chk("vde", 32'(vde_o), 32'(e_vde));
        chk("hsync", 32'(hs_o), 32'(e_hs));
        chk("vsync", 32'(vs_o), 32'(e_vs));
        chk("mode", 32'(mode_o), 32'(m_mode));
        chk("changed", 32'(changed_o), 32'(m_changed));
        chk("ready", 32'(req_ready), 32'(!m_pending && !rst));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_fb();
        vs_i = 1'b0;
        tick(); tick(); tick();
        vs_i = 1'b1;
        tick();
    endtask

    task automatic request(input logic [1:0] m);
        mode_req  = m;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int exp6 [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
        rst = 1'b1; data_i = 24'hABCDEF; vde_i = 1'b1; hs_i = 1'b0; vs_i = 1'b0;
        mode_req = 2'b00; req_valid = 1'b0; auto_en = 1'b0;

        // 1. reset mid-line
        tick(); tick(); tick();
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_mode", 32'(mode_o), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        tick();
        chk("rel_ready", 32'(req_ready), 32'h1);
        chk("rel_data", 32'(data_o), 32'hABCDEF);

        // 2. random video and requests against the model
        for (int i = 0; i < 1000; i++) begin
            data_i    = 24'($urandom);
            vde_i     = 1'($urandom);
            hs_i      = 1'($urandom);
            vs_i      = ($urandom_range(0, 7) == 0);
            req_valid = 1'($urandom);
            mode_req  = 2'($urandom);
            auto_en   = 1'($urandom);
            tick();
        end
        req_valid = 1'b0; auto_en = 1'b0;

        // 3. request mid-frame, applied at the boundary 400 cycles later
        do_reset();
        vs_i = 1'b0;
        repeat (5) tick();
        request(2'b01);
        for (int i = 0; i < 399; i++) begin
            tick();
        end
        chk("t3_ready_wait", 32'(req_ready), 32'h0);
        chk("t3_mode_wait", 32'(mode_o), 32'h0);
        vs_i = 1'b1;
        tick();
        chk("t3_mode", 32'(mode_o), 32'h1);
        chk("t3_changed", 32'(changed_o), 32'h1);
        chk("t3_ready", 32'(req_ready), 32'h1);

        // 4. accept in the boundary cycle, then an equal-value request
        vs_i = 1'b0;
        tick(); tick(); tick();
        vs_i = 1'b1; mode_req = 2'b10; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("t4_same_fb_mode", 32'(mode_o), 32'h1);
        chk("t4_same_fb_chg", 32'(changed_o), 32'h0);
        do_fb();
        chk("t4_next_fb_mode", 32'(mode_o), 32'h2);
        chk("t4_next_fb_chg", 32'(changed_o), 32'h1);
        vs_i = 1'b0;
        tick();
        request(2'b10);
        do_fb();
        chk("t4_eq_mode", 32'(mode_o), 32'h2);
        chk("t4_eq_chg", 32'(changed_o), 32'h0);
        chk("t4_eq_ready", 32'(req_ready), 32'h1);

        // 5. reset drops a pending request
        do_reset();
        vs_i = 1'b0;
        tick();
        request(2'b11);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        do_fb();
        chk("t5_fb1_mode", 32'(mode_o), 32'h0);
        do_fb();
        chk("t5_fb2_mode", 32'(mode_o), 32'h0);
        chk("t5_fb2_chg", 32'(changed_o), 32'h0);

        // 6. auto-cycle
        do_reset();
        auto_en = 1'b1;
`ifdef RGB_SWAP_AUTO_CYCLE_EN
        for (int i = 0; i < 8; i++) begin
            do_fb();
            chk($sformatf("t6_fb%0d", i + 1), 32'(mode_o), 32'(exp6[i]));
        end
        do_fb();
        chk("t6_pre_manual", 32'(mode_o), 32'h0);
        vs_i = 1'b0;
        tick();
        request(2'b11);
        do_fb();
        chk("t6_manual", 32'(mode_o), 32'h3);
        do_fb();
        chk("t6_restart1", 32'(mode_o), 32'h3);
        do_fb();
        chk("t6_restart2", 32'(mode_o), 32'h0);
`else
        for (int i = 0; i < 8; i++) begin
            do_fb();
            chk($sformatf("t6_off_fb%0d", i + 1), 32'(mode_o), 32'(exp6[0]));
        end
`endif
        auto_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
